// File: rtl/break_counter_ctrl.sv
// Button-driven wrapping up/down counter with LED drive for the break-away PMOD.
// Optional auto-repeat on a held inc/dec button: define BREAK_CTRL_AUTOREPEAT_EN.
module break_counter_ctrl #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned REPEAT_DELAY  = 12000000,
    parameter int unsigned REPEAT_PERIOD = 3000000
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_button_inc,
    input  logic             i_button_clr,
    input  logic             i_button_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_event,
    output logic [1:0]       o_op,
    output logic             o_wrap,
    output logic [4:0]       o_leds
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    if (WIDTH < 1 || WIDTH > 8 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("break_counter_ctrl: illegal parameter value");
    end

    logic [2:0]       level;
    logic [2:0]       rise;
    logic [2:0]       prev_q;
    logic [1:0]       op_rise;
    logic [1:0]       op_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             event_q;
    logic [1:0]       op_q;
    logic [4:0]       leds_q, leds_d;
    logic [2:0]       cnt_low;

    // Bit order throughout: [0]=inc, [1]=dec, [2]=clr.
    assign level = {i_button_clr, i_button_dec, i_button_inc};
    assign rise  = level & ~prev_q;

    always_comb begin
        op_rise = OP_NONE;
        if (rise[2])                op_rise = OP_CLR;
        else if (rise[0] && rise[1]) op_rise = OP_NONE;
        else if (rise[0])           op_rise = OP_INC;
        else if (rise[1])           op_rise = OP_DEC;
    end

`ifdef BREAK_CTRL_AUTOREPEAT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

    localparam logic [23:0] DELAY_LOAD  = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] PERIOD_LOAD = 24'(REPEAT_PERIOD - 1);

    state_t      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic        rep_dec_q, rep_dec_d;
    logic        held;
    logic        other_rise;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rep_dec_d  = rep_dec_q;
        op_d       = op_rise;
        held       = rep_dec_q ? i_button_dec : i_button_inc;
        other_rise = rise[2] | (rep_dec_q ? rise[0] : rise[1]);
        case (state_q)
            ST_IDLE: begin
                if (op_rise == OP_INC || op_rise == OP_DEC) begin
                    state_d   = ST_DELAY;
                    rep_dec_d = (op_rise == OP_DEC);
                    timer_d   = DELAY_LOAD;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // A fresh rise wins over a due step; its own op already sits in op_d.
                if (!held || other_rise) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    op_d    = rep_dec_q ? OP_DEC : OP_INC;
                    timer_d = PERIOD_LOAD;
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            rep_dec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rep_dec_q <= rep_dec_d;
        end
    end
`else
    assign op_d = op_rise;
`endif

    always_comb begin
        count_d = count_q;
        wrap_d  = wrap_q;
        case (op_d)
            OP_INC: begin
                count_d = count_q + 1'b1;
                if (count_q == '1) wrap_d = 1'b1;
            end
            OP_DEC: begin
                count_d = count_q - 1'b1;
                if (count_q == '0) wrap_d = 1'b1;
            end
            OP_CLR: begin
                count_d = '0;
                wrap_d  = 1'b0;
            end
            default: ;
        endcase
        // Narrow counters zero-extend, so missing count bits show as dark LEDs.
        cnt_low = 3'(count_d);
        leds_d  = {cnt_low[2], cnt_low[0], |level, wrap_d, cnt_low[1]};
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev_q  <= '1;
            count_q <= '0;
            wrap_q  <= 1'b0;
            event_q <= 1'b0;
            op_q    <= OP_NONE;
            leds_q  <= '0;
        end else begin
            prev_q  <= level;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            event_q <= (op_d != OP_NONE);
            op_q    <= op_d;
            leds_q  <= leds_d;
        end
    end

    assign o_count = count_q;
    assign o_event = event_q;
    assign o_op    = op_q;
    assign o_wrap  = wrap_q;
    assign o_leds  = leds_q;

endmodule

// File: tb/tb_break_counter_ctrl.sv
// Directed bench for break_counter_ctrl: per-cycle comparison against a press/hold model,
// plus literal checkpoints. Honours BREAK_CTRL_AUTOREPEAT_EN like the design.
module tb_break_counter_ctrl;

    localparam int W  = 3;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int M  = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         b_inc = 1'b0, b_dec = 1'b0, b_clr = 1'b0;
    logic [W-1:0] o_count;
    logic         o_event;
    logic [1:0]   o_op;
    logic         o_wrap;
    logic [4:0]   o_leds;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt = 0;
    int ev0;

    break_counter_ctrl #(.WIDTH(W), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_button_inc(b_inc), .i_button_clr(b_clr), .i_button_dec(b_dec),
        .o_count(o_count), .o_event(o_event), .o_op(o_op), .o_wrap(o_wrap), .o_leds(o_leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count in plain integers; held button tracked by press age (cycles since press).
    int m_count, m_wrap, m_event, m_op, m_leds;
    bit p_inc, p_dec, p_clr;
    int rep_btn;  // 0 none, 1 inc, 2 dec
    int age;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_wrap = 0; m_event = 0; m_op = 0; m_leds = 0;
            p_inc = 1; p_dec = 1; p_clr = 1;
            rep_btn = 0; age = 0;
        end else begin
            bit r_inc, r_dec, r_clr, was_idle;
            int op;
            r_inc = b_inc & !p_inc;
            r_dec = b_dec & !p_dec;
            r_clr = b_clr & !p_clr;
            op = 0;
            if (r_clr) op = 3;
            else if (r_inc && r_dec) op = 0;
            else if (r_inc) op = 1;
            else if (r_dec) op = 2;
            was_idle = (rep_btn == 0);
`ifdef BREAK_CTRL_AUTOREPEAT_EN
            if (!was_idle) begin
                if (!((rep_btn == 1) ? b_inc : b_dec) || r_inc || r_dec || r_clr) begin
                    rep_btn = 0;
                end else begin
                    age++;
                    if (age >= RD && (age - RD) % RP == 0) op = rep_btn;
                end
            end
            if (was_idle && (op == 1 || op == 2)) begin
                rep_btn = op;
                age = 0;
            end
`endif
            if (op == 1) begin
                if (m_count == M - 1) m_wrap = 1;
                m_count = (m_count + 1) % M;
            end else if (op == 2) begin
                if (m_count == 0) m_wrap = 1;
                m_count = (m_count + M - 1) % M;
            end else if (op == 3) begin
                m_count = 0;
                m_wrap = 0;
            end
            m_event = (op != 0);
            m_op = op;
            m_leds = (((m_count >> 2) & 1) << 4) | ((m_count & 1) << 3) |
                     ((b_inc | b_dec | b_clr) << 2) | (m_wrap << 1) | ((m_count >> 1) & 1);
            p_inc = b_inc; p_dec = b_dec; p_clr = b_clr;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", int'(o_count), m_count);
            chk("event", int'(o_event), m_event);
            chk("op",    int'(o_op),    m_op);
            chk("wrap",  int'(o_wrap),  m_wrap);
            chk("leds",  int'(o_leds),  m_leds);
            if (o_event) ev_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic btn(input logic i, input logic d, input logic c);
        b_inc = i; b_dec = d; b_clr = c;
    endtask

    // One-cycle press then one idle cycle; afterwards activity LED is dark again.
    task automatic press(input logic i, input logic d, input logic c);
        btn(i, d, c);
        cyc(1);
        btn(0, 0, 0);
        cyc(1);
    endtask

    initial begin
        cyc(2);
        chk("rst_count", int'(o_count), 0);
        chk("rst_event", int'(o_event), 0);
        chk("rst_op",    int'(o_op),    0);
        chk("rst_wrap",  int'(o_wrap),  0);
        chk("rst_leds",  int'(o_leds),  0);
        rst_n = 1'b1;
        cyc(2);

        // Three separate increments.
        ev0 = ev_cnt;
        press(1, 0, 0);
        chk("t1_c1", int'(o_count), 1);
        chk("t1_l1", int'(o_leds), 5'b01000);
        press(1, 0, 0);
        chk("t1_c2", int'(o_count), 2);
        chk("t1_l2", int'(o_leds), 5'b00001);
        press(1, 0, 0);
        chk("t1_c3", int'(o_count), 3);
        chk("t1_l3", int'(o_leds), 5'b01001);
        chk("t1_ev", ev_cnt - ev0, 3);

        // Wrap up, wrap down, clear.
        repeat (4) press(1, 0, 0);
        chk("t2_c7", int'(o_count), 7);
        press(1, 0, 0);
        chk("t2_c0", int'(o_count), 0);
        chk("t2_w1", int'(o_wrap), 1);
        chk("t2_led1", int'(o_leds[1]), 1);
        press(0, 1, 0);
        chk("t2_c7b", int'(o_count), 7);
        chk("t2_w1b", int'(o_wrap), 1);
        btn(0, 0, 1);
        cyc(1);
        chk("t2_clr_op", int'(o_op), 2'b11);
        chk("t2_clr_ev", int'(o_event), 1);
        btn(0, 0, 0);
        cyc(1);
        chk("t2_clr_c", int'(o_count), 0);
        chk("t2_clr_w", int'(o_wrap), 0);

        // Simultaneous rises.
        repeat (5) press(1, 0, 0);
        ev0 = ev_cnt;
        press(1, 1, 0);
        chk("t3_cancel_c", int'(o_count), 5);
        chk("t3_cancel_ev", ev_cnt - ev0, 0);
        btn(1, 0, 1);
        cyc(1);
        chk("t3_ic_op", int'(o_op), 2'b11);
        btn(0, 0, 0);
        cyc(1);
        chk("t3_ic_c", int'(o_count), 0);
        press(1, 0, 0);
        btn(1, 1, 1);
        cyc(1);
        chk("t3_idc_op", int'(o_op), 2'b11);
        btn(0, 0, 0);
        cyc(1);
        chk("t3_idc_c", int'(o_count), 0);

        // Button held through reset must be re-pressed.
        btn(1, 0, 0);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        ev0 = ev_cnt;
        cyc(5);
        chk("t4_held_c", int'(o_count), 0);
        chk("t4_held_ev", ev_cnt - ev0, 0);
        btn(0, 0, 0);
        cyc(1);
        press(1, 0, 0);
        chk("t4_repress", int'(o_count), 1);

`ifdef BREAK_CTRL_AUTOREPEAT_EN
        press(0, 0, 1);
        ev0 = ev_cnt;
        // Held for 21 cycles: press step at age 0, repeats at ages 8, 12, 16, 20.
        btn(0, 1, 0);
        cyc(21);
        btn(0, 0, 0);
        cyc(1);
        chk("t5_c", int'(o_count), 3);
        chk("t5_ev", ev_cnt - ev0, 5);
        cyc(10);
        chk("t5_rel_ev", ev_cnt - ev0, 5);
        btn(0, 1, 0);
        cyc(5);
        btn(1, 1, 0);
        cyc(15);
        btn(0, 0, 0);
        cyc(2);
        chk("t5_inc_c", int'(o_count), 3);
        chk("t5_inc_ev", ev_cnt - ev0, 7);
        // Reset during a repeat run stops it.
        btn(0, 1, 0);
        cyc(10);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        ev0 = ev_cnt;
        cyc(12);
        btn(0, 0, 0);
        cyc(2);
        chk("t5_rst_c", int'(o_count), 0);
        chk("t5_rst_ev", ev_cnt - ev0, 0);
`else
        press(0, 0, 1);
        ev0 = ev_cnt;
        btn(1, 0, 0);
        cyc(100);
        btn(0, 0, 0);
        cyc(2);
        chk("t6_ev", ev_cnt - ev0, 1);
        chk("t6_c", int'(o_count), 1);
`endif

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/break_counter_ctrl.md
Name: break_counter_ctrl

Overview:
Sequencing controller for the break-away PMOD up/down counter. It takes the three debounced button levels in the `i_clock` domain and performs these steps:
- rising-edge detection on each button;
- arbitration of simultaneous presses into one counter operation per cycle;
- update of a wrapping counter;
- drive of all five break-away LEDs, including wrap and activity indicators.

It replaces direct posedge-on-button counting with a fully synchronous single-clock design. It sits between the three button debouncers and the LED pins.

Parameters:
- WIDTH, 3, counter width in bits, legal range 1..8.
- REPEAT_DELAY, 12000000, cycles a button is held before auto-repeat starts (only with BREAK_CTRL_AUTOREPEAT_EN). Must be >= 2.
- REPEAT_PERIOD, 3000000, cycles between auto-repeat steps (only with BREAK_CTRL_AUTOREPEAT_EN). Must be >= 2.

Ports:
- i_clock  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_button_inc  in  1  debounced increment button level, synchronous to i_clock, active-high.
- i_button_clr  in  1  debounced clear button level, synchronous, active-high.
- i_button_dec  in  1  debounced decrement button level, synchronous, active-high.
- o_count  out  WIDTH  current counter value.
- o_event  out  1  one-cycle pulse, high in the cycle o_count takes a new value from an accepted operation.
- o_op  out  2  operation tagged with o_event: 01 inc, 10 dec, 11 clr, 00 none.
- o_wrap  out  1  sticky wrap flag.
- o_leds  out  5  break-away LED drive.

Behaviour:
- Reset: asynchronous and active-low; one clock (i_clock).
  - Reset values: o_count=0, o_event=0, o_op=00, o_wrap=0, o_leds=00000.
  - The three previous-level registers reset to 1, so a button held through reset must be released and pressed again before it acts.
  - Reset asserted mid-operation aborts everything immediately, including any auto-repeat.
- Edge detect: rise_x = level_x & ~prev_x. prev_x is registered every cycle.
- Arbitration of rises in cycle N, in priority order:
  - rise_clr set: operation is clr, whatever inc/dec do.
  - rise_inc and rise_dec both set, no rise_clr: no operation, no event (they cancel).
  - Only rise_inc set: inc.
  - Only rise_dec set: dec.
- Latency: the operation chosen in cycle N is visible on o_count, o_event and o_op after the clock edge ending cycle N (1 cycle).
- Arithmetic is modulo 2^WIDTH:
  - inc at 2^WIDTH-1 gives 0 and sets o_wrap.
  - dec at 0 gives 2^WIDTH-1 and sets o_wrap.
  - clr sets o_count=0 and clears o_wrap in the same edge.
  - o_wrap otherwise holds.
- o_event and o_op are registered and are high/non-zero for exactly one cycle per accepted operation. They are 0 / 00 otherwise.
- o_leds (registered with the count):
  - [3] = count[0]
  - [0] = count[1] if WIDTH>=2, else 0
  - [4] = count[2] if WIDTH>=3, else 0
  - [1] = o_wrap
  - [2] = registered OR of the three button levels (activity).
  - Bits above 2 of the count are not shown.

Optional Feature:
Macro: BREAK_CTRL_AUTOREPEAT_EN.

With the macro, an auto-repeat FSM is built with states IDLE, DELAY and REPEAT, plus a 24-bit down-timer.
- IDLE to DELAY: on an accepted inc or dec. The held button is latched and the timer is loaded with REPEAT_DELAY-1.
- DELAY:
  - Counts down while the latched button level stays high.
  - At timer=0: issue a repeat step, load REPEAT_PERIOD-1, go to REPEAT.
- REPEAT: counts down; at 0 issue a repeat step and reload REPEAT_PERIOD-1.
- Return to IDLE from DELAY or REPEAT, with no step in that cycle, when any of these happens:
  - the latched level goes low;
  - any rise on another button;
  - any clr.
- A repeat step is the same operation as the latched button. It uses the same arithmetic, o_wrap, o_event and o_op rules, and has the same 1-cycle latency.
- A new rise takes priority over a repeat step due in the same cycle.

Without the macro, no FSM or timer is built. A held button produces exactly one operation, and the REPEAT_* parameters are ignored.

Test Plan:
WIDTH=3 throughout; REPEAT_DELAY=8 and REPEAT_PERIOD=4 where auto-repeat is enabled.
1. Reset, then 3 separate inc presses -> o_count 1,2,3; o_leds=01000,00001,01001; three single-cycle o_event pulses with o_op=01.
2. From count 7: inc -> count 0, o_wrap=1, o_leds[1]=1. Then dec -> count 7, o_wrap stays 1. Then clr -> count 0, o_wrap=0, o_op=11.
3. Same-cycle rises:
   - inc+dec from count 5 -> count stays 5, no o_event.
   - inc+clr -> count 0, o_op=11.
   - inc+dec+clr -> count 0, o_op=11.
4. Hold inc through deassertion of i_reset_n, release reset with inc still high -> no operation. Release inc and press again -> count 1.
5. With BREAK_CTRL_AUTOREPEAT_EN, hold dec for 20 cycles from count 0:
   - Expected counts: 7 at the edge after the press; then 6 after 8 more cycles; then 5, 4, 3 every 4 cycles.
   - Release -> no further events.
   - Pressing inc mid-hold applies inc and stops repeat.
6. Without the macro, hold inc for 100 cycles -> exactly one o_event, count 1.
